// File: rtl/bitlet_ce_ctrl.sv
// rtl/bitlet_ce_ctrl.sv - Bitlet compute-engine job/tile sequencer
// Fetches one operand group per tile, strobes the engine, waits for its Asel_vld burst to drain.
module bitlet_ce_ctrl #(
   parameter int N_TOTAL = 64,
   parameter int N_CH    = 24,
   parameter int TILE_W  = 16,
   parameter int TO_W    = 8,
   localparam int NC_W   = $clog2(N_TOTAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_vld,
   output logic              job_rdy,
   input  logic [TILE_W-1:0] job_tiles,
   input  logic [NC_W-1:0]   job_ncalc,
   input  logic [N_CH-1:0]   job_prune,
   input  logic              job_abort,
   output logic              op_req,
   output logic [TILE_W-1:0] op_idx,
   input  logic              op_ack,
   output logic              ce_wabs_vld,
   output logic              ce_flush,
   output logic [NC_W-1:0]   ce_ncalc,
   output logic [N_CH-1:0]   ce_prune,
   input  logic              ce_asel_vld,
   output logic              tile_done,
   output logic              tile_last,
   output logic              job_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t            state, state_nxt;
   logic [TILE_W-1:0] tile;
   logic [TILE_W-1:0] tiles_q;
   logic [TO_W-1:0]   timer;
   logic [NC_W-1:0]   ncalc_q;
   logic [N_CH-1:0]   prune_q;
   logic              done_q;
   logic              accept;
   logic              tile_end;
   logic              last;

   assign last     = (tile == tiles_q);
   assign op_idx   = tile;
   assign ce_ncalc = ncalc_q;
   assign ce_prune = prune_q;
   assign job_done = done_q;

   always_comb begin
      state_nxt   = state;
      job_rdy     = 1'b0;
      op_req      = 1'b0;
      ce_wabs_vld = 1'b0;
      ce_flush    = 1'b0;
      tile_done   = 1'b0;
      tile_last   = 1'b0;
      accept      = 1'b0;
      tile_end    = 1'b0;
      case (state)
         S_IDLE: begin
            job_rdy = 1'b1;
            if (job_vld) begin
               accept    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            op_req = !job_abort;
            if (job_abort)   state_nxt = S_FLUSH;
            else if (op_ack) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (job_abort) state_nxt = S_FLUSH;
            else begin
               ce_wabs_vld = 1'b1;
               state_nxt   = S_WAIT;
            end
         end
         S_WAIT: begin
            // An all-pruned tile never raises Asel_vld; the timeout closes it out.
            if (job_abort)          state_nxt = S_FLUSH;
            else if (ce_asel_vld)   state_nxt = S_DRAIN;
            else if (timer == '1)   tile_end  = 1'b1;
         end
         S_DRAIN: begin
            if (job_abort)          state_nxt = S_FLUSH;
            else if (!ce_asel_vld)  tile_end  = 1'b1;
         end
         S_FLUSH: begin
            ce_flush  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (tile_end) begin
         tile_done = 1'b1;
         tile_last = last;
         state_nxt = last ? S_FLUSH : S_FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         tile    <= '0;
         tiles_q <= '0;
         timer   <= '0;
         ncalc_q <= '0;
         prune_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == S_FLUSH);
         if (accept) begin
            tiles_q <= job_tiles;
            ncalc_q <= job_ncalc;
            prune_q <= job_prune;
            tile    <= '0;
         end else if (tile_end && !last) begin
            tile <= tile + TILE_W'(1);
         end
         if (state == S_ISSUE)
            timer <= '0;
         else if (state == S_WAIT && !ce_asel_vld)
            timer <= timer + TO_W'(1);
      end
   end

endmodule

// File: tb/tb_bitlet_ce_ctrl.sv
// tb/tb_bitlet_ce_ctrl.sv - directed bench for bitlet_ce_ctrl
// Plays operand buffer and engine cycle by cycle; counts observed events per job.
module tb_bitlet_ce_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_vld = 1'b0;
   logic        job_rdy;
   logic [15:0] job_tiles = '0;
   logic [5:0]  job_ncalc = '0;
   logic [23:0] job_prune = '0;
   logic        job_abort = 1'b0;
   logic        op_req;
   logic [15:0] op_idx;
   logic        op_ack = 1'b0;
   logic        ce_wabs_vld;
   logic        ce_flush;
   logic [5:0]  ce_ncalc;
   logic [23:0] ce_prune;
   logic        ce_asel_vld = 1'b0;
   logic        tile_done;
   logic        tile_last;
   logic        job_done;

   int n_tests = 0;
   int n_fail  = 0;

   int n_wabs, n_tdone, n_tlast, tlast_at, n_flush, n_jdone, n_accept, rdy_busy;
   int max_req, gap_td, ack_to_wabs, abort_cyc, flush_cyc, jdone_cyc, rdy_at_done;
   int n_fetch, ncalc_seen, prune_seen, finished;
   int idx_log [0:7];

   bitlet_ce_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .job_vld     (job_vld),
      .job_rdy     (job_rdy),
      .job_tiles   (job_tiles),
      .job_ncalc   (job_ncalc),
      .job_prune   (job_prune),
      .job_abort   (job_abort),
      .op_req      (op_req),
      .op_idx      (op_idx),
      .op_ack      (op_ack),
      .ce_wabs_vld (ce_wabs_vld),
      .ce_flush    (ce_flush),
      .ce_ncalc    (ce_ncalc),
      .ce_prune    (ce_prune),
      .ce_asel_vld (ce_asel_vld),
      .tile_done   (tile_done),
      .tile_last   (tile_last),
      .job_done    (job_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   // One job: ack arrives ack_d cycles after op_req rises, Asel_vld high asel_len cycles per tile,
   // optional abort in the third drain cycle of tile abort_tile, optional job_vld held through the job.
   task automatic run_job(input logic [15:0] tiles, input logic [5:0] ncalc, input logic [23:0] prune,
                          input int ack_d, input int asel_len, input int abort_tile, input bit hold_vld);
      int cyc = 0, req_cnt = 0, asel_left = 0, asel_drv = 0, wabs_cyc = 0, ack_cyc = 0;
      bit aborted = 1'b0;
      n_wabs = 0; n_tdone = 0; n_tlast = 0; tlast_at = -1; n_flush = 0; n_jdone = 0;
      n_accept = 0; rdy_busy = 0; max_req = 0; gap_td = -1; ack_to_wabs = -1;
      abort_cyc = -1; flush_cyc = -1; jdone_cyc = -1; rdy_at_done = -1;
      n_fetch = 0; ncalc_seen = -1; prune_seen = -1; finished = 0;
      for (int i = 0; i < 8; i++) idx_log[i] = -1;
      while (cyc < 3000 && finished == 0) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            job_vld   = 1'b1;
            job_tiles = tiles;
            job_ncalc = ncalc;
            job_prune = prune;
         end else begin
            job_vld   = hold_vld && (n_flush == 0);
            op_ack    = (req_cnt == ack_d);
            if (op_ack) ack_cyc = cyc;
            job_abort = 1'b0;
            if (abort_tile >= 0 && !aborted && n_wabs == abort_tile + 1 && asel_drv == 2) begin
               job_abort   = 1'b1;
               aborted     = 1'b1;
               abort_cyc   = cyc;
               ce_asel_vld = 1'b1;
               asel_left   = 0;
            end else if (asel_left > 0) begin
               ce_asel_vld = 1'b1;
               asel_left--;
               asel_drv++;
            end else begin
               ce_asel_vld = 1'b0;
            end
         end
         @(negedge clk);
         if (job_vld && job_rdy) n_accept++;
         if (job_rdy && !job_done && cyc > 0) rdy_busy++;
         if (op_req) begin
            if (req_cnt == 0 && n_fetch < 8) begin
               idx_log[n_fetch] = int'(op_idx);
               n_fetch++;
            end
            req_cnt++;
            if (req_cnt > max_req) max_req = req_cnt;
         end else begin
            req_cnt = 0;
         end
         if (ce_wabs_vld) begin
            n_wabs++;
            wabs_cyc    = cyc;
            ack_to_wabs = cyc - ack_cyc;
            asel_left   = asel_len;
            asel_drv    = 0;
            ncalc_seen  = int'(ce_ncalc);
            prune_seen  = int'(ce_prune);
         end
         if (tile_done) begin
            gap_td = cyc - wabs_cyc;
            if (tile_last) begin
               tlast_at = n_tdone;
               n_tlast++;
            end
            n_tdone++;
         end
         if (ce_flush) begin
            n_flush++;
            flush_cyc = cyc;
         end
         if (job_done) begin
            n_jdone++;
            jdone_cyc   = cyc;
            rdy_at_done = int'(job_rdy);
            finished    = 1;
         end
         cyc++;
      end
      job_vld = 1'b0; op_ack = 1'b0; job_abort = 1'b0; ce_asel_vld = 1'b0;
      check("job_completes", finished, 1);
   endtask

   initial begin
      int evts;
      #12;
      check("rst_job_rdy", 32'(job_rdy), 1);
      check("rst_strobes", 32'({op_req, ce_wabs_vld, ce_flush, tile_done, tile_last, job_done}), 0);
      check("rst_cfg", 32'({ce_ncalc, ce_prune}), 0);
      check("rst_op_idx", 32'(op_idx), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 3 tiles, ack after 1 cycle, 5-cycle bursts
      run_job(16'd2, 6'd63, 24'hFFFFFF, 1, 5, -1, 1'b0);
      check("t1_wabs", n_wabs, 3);
      check("t1_tile_done", n_tdone, 3);
      check("t1_tile_last_cnt", n_tlast, 1);
      check("t1_tile_last_on_3rd", tlast_at, 2);
      check("t1_op_idx0", idx_log[0], 0);
      check("t1_op_idx1", idx_log[1], 1);
      check("t1_op_idx2", idx_log[2], 2);
      check("t1_req_len", max_req, 2);
      check("t1_drain_gap", gap_td, 6);
      check("t1_ncalc", ncalc_seen, 63);
      check("t1_prune", prune_seen, 32'hFFFFFF);
      check("t1_flush", n_flush, 1);
      check("t1_done_after_flush", jdone_cyc - flush_cyc, 1);
      check("t1_rdy_busy", rdy_busy, 0);
      check("t1_rdy_at_done", rdy_at_done, 1);

      // slow operand buffer
      run_job(16'd0, 6'd31, 24'h0000FF, 10, 3, -1, 1'b0);
      check("t2_req_len", max_req, 11);
      check("t2_ack_to_wabs", ack_to_wabs, 1);
      check("t2_wabs", n_wabs, 1);
      check("t2_tile_done", n_tdone, 1);

      // Asel_vld never rises: start timeout closes each tile
      run_job(16'd1, 6'd5, 24'h000000, 1, 0, -1, 1'b0);
      check("t3_timeout_gap", gap_td, 256);
      check("t3_tile_done", n_tdone, 2);
      check("t3_tile_last", tlast_at, 1);
      check("t3_job_done", n_jdone, 1);
      check("t3_ncalc", ncalc_seen, 5);

      // abort in drain of tile 1 of 4
      run_job(16'd3, 6'd15, 24'hABCDEF, 1, 5, 1, 1'b0);
      check("t4_wabs", n_wabs, 2);
      check("t4_tile_done", n_tdone, 1);
      check("t4_tile_last", n_tlast, 0);
      check("t4_flush", n_flush, 1);
      check("t4_flush_after_abort", flush_cyc - abort_cyc, 1);
      check("t4_done_after_flush", jdone_cyc - flush_cyc, 1);
      check("t4_rdy_at_done", rdy_at_done, 1);

      // single tile, job_vld held for the whole job
      run_job(16'd0, 6'd1, 24'h555555, 1, 2, -1, 1'b1);
      check("t5_accepts", n_accept, 1);
      check("t5_fetches", n_fetch, 1);
      check("t5_tile_done", n_tdone, 1);
      check("t5_done_and_last", tlast_at, 0);
      check("t5_rdy_busy", rdy_busy, 0);

      // async reset while waiting for Asel_vld
      @(posedge clk); #1;
      job_vld = 1'b1; job_tiles = 16'd1; job_ncalc = 6'd7; job_prune = 24'h00F0F0;
      @(posedge clk); #1;
      job_vld = 1'b0; op_ack = 1'b1;
      @(posedge clk); #1;
      op_ack = 1'b0;
      @(negedge clk);
      check("t6_wabs", 32'(ce_wabs_vld), 1);
      repeat (4) @(posedge clk);
      #3;
      check("t6_pre_ncalc", 32'(ce_ncalc), 7);
      check("t6_pre_rdy", 32'(job_rdy), 0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_rdy", 32'(job_rdy), 1);
      check("t6_rst_strobes", 32'({op_req, ce_wabs_vld, ce_flush, tile_done, tile_last, job_done}), 0);
      check("t6_rst_cfg", 32'({ce_ncalc, ce_prune}), 0);
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      evts = 0;
      repeat (4) begin
         @(negedge clk);
         if (ce_flush || job_done || !job_rdy) evts++;
      end
      check("t6_no_flush_after_rst", evts, 0);
      run_job(16'd0, 6'd9, 24'h123456, 2, 4, -1, 1'b0);
      check("t6_next_tile_done", n_tdone, 1);
      check("t6_next_job_done", n_jdone, 1);
      check("t6_next_ncalc", ncalc_seen, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
